hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Hazard/sequencing controller for the 5-stage pipeline.
// - Drives the 2-bit selects of the execute-stage mux3 forwarding muxes (SrcA/SrcB).
// - Generates stall/flush for load-use hazards and taken branches.
// - Sequences a multi-cycle execute unit (mul/div) through a small FSM with a timeout and a stall-cycle counter.
// PARAMETERS
// - TIMEOUT  64  max BUSY cycles before McError; must be >= 2
// - CNT_W    32  width of StallCount
// PORTS
// clk         in   1      clock, rising edge
// reset       in   1      synchronous, active-high
// Rs1D,Rs2D   in   5      source regs, decode stage
// Rs1E,Rs2E   in   5      source regs, execute stage
// RdE,RdM,RdW in   5      dest regs, E/M/W stages
// RegWriteM   in   1      M-stage instr writes RF
// RegWriteW   in   1      W-stage instr writes RF
// ResultSrcE0 in   1      E-stage instr is a load
// PCSrcE      in   1      branch/jump taken in E
// McStartE    in   1      E-stage instr uses multi-cycle unit; held while E stalled
// McDone      in   1      multi-cycle unit result valid this cycle
// ForwardAE   out  2      SrcA mux3 select: 00 RF, 01 ResultW, 10 ALUResultM
// ForwardBE   out  2      SrcB mux3 select, same encoding
// StallF      out  1      hold PC
// StallD      out  1      hold IF/ID
// StallE      out  1      hold ID/EX
// FlushD      out  1      clear IF/ID
// FlushE      out  1      clear ID/EX
// FlushM      out  1      clear EX/MEM (bubble)
// McBusy      out  1      FSM in BUSY
// McError     out  1      sticky timeout flag
// StallCount  out  CNT_W  cycles with StallF=1, saturating
// BEHAVIOUR
// - Reset (sync, highest priority):
//   - state=IDLE; BUSY counter=0; McError=0; StallCount=0.
//   - While reset=1, all Stall*/Flush* = 0 and Forward* = 00.
// - Forwarding (combinational, per source; shown for A, B identical with Rs2E):
//   - 10 if RegWriteM & RdM!=0 & RdM==Rs1E
//   - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E
//   - else 00
//   - Code 11 is never driven; M has priority over W.
// - lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
// - mcStall:
//   - IDLE: McStartE & !McDone
//   - BUSY: !McDone
//   - ERR: 1
// - Stall/flush outputs (combinational):
//   - StallF = StallD = lwStall | mcStall
//   - StallE = mcStall
//   - FlushD = PCSrcE & !mcStall
//   - FlushE = (lwStall | PCSrcE) & !mcStall
//   - FlushM = mcStall
// - FSM {IDLE, BUSY, ERR}:
//   - IDLE -> BUSY when McStartE & !McDone. If McDone arrives with start, no stall and stay IDLE.
//   - BUSY -> IDLE when McDone; stall drops in that same cycle, so E advances.
//   - BUSY -> ERR when counter==TIMEOUT-1 & !McDone. McDone wins on a tie.
//   - ERR holds until reset; McError=1 in ERR.
// - Counter:
//   - Cleared on IDLE->BUSY.
//   - +1 each BUSY cycle.
//   - Width $clog2(TIMEOUT+1).
// - McBusy = (state==BUSY), registered.
// - StallCount: +1 on each clock where StallF=1 and reset=0; saturates at all-ones.
// - Reset mid-BUSY: next cycle IDLE, counters 0, no residual stall.
// TESTING
// - Fwd: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01.
// - Fwd x0: RdM=0, Rs1E=0, RegWriteM=1 -> ForwardAE=00; ForwardAE/BE never 11 over random sweep.
// - Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0.
//   - Same with RdE=0 -> all 0.
// - Branch: PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1.
//   - Same during BUSY -> FlushD=FlushE=0.
// - Mul: McStartE=1, McDone after 4 cycles -> StallF/D/E and FlushM high 4 cycles, low on the McDone cycle.
//   - McBusy=1 for 4 cycles.
//   - StallCount +4.
// - Timeout: TIMEOUT=8, McDone never -> McError=1 from cycle 9 on, stalls held.
//   - reset -> IDLE, McError=0, StallCount=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use / branch stall-flush generation and a multi-cycle execute unit sequencer.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             McStartE,
  input  logic             McDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McBusy,
  output logic             McError,
  output logic [CNT_W-1:0] StallCount
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             mc_stall;
  logic             lw_stall;
  logic [1:0]       fwd_a, fwd_b;

  // The M stage holds the younger result, so it wins over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic [4:0] rd_w,
                                         input logic       wr_m,
                                         input logic       wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign fwd_a    = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign fwd_b    = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    mc_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (McStartE && !McDone) begin
          mc_stall    = 1'b1;
          state_nxt   = BUSY;
          tmo_cnt_nxt = '0;
        end
      end
      BUSY: begin
        mc_stall    = !McDone;
        tmo_cnt_nxt = tmo_cnt + 1'b1;
        if (McDone)
          state_nxt = IDLE;
        else if (tmo_cnt == TMO_LAST)
          state_nxt = ERR;
      end
      ERR: begin
        mc_stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Reset forces a clean pipeline: no stalls, flushes or forwarding while asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = lw_stall || mc_stall;
      StallD    = lw_stall || mc_stall;
      StallE    = mc_stall;
      FlushD    = PCSrcE && !mc_stall;
      FlushE    = (lw_stall || PCSrcE) && !mc_stall;
      FlushM    = mc_stall;
    end
  end

  assign McBusy  = (state == BUSY);
  assign McError = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= '0;
    else if (StallF)
      StallCount <= sat_inc(StallCount);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table, random forwarding sweep,
// and hand-written multi-cycle sequences (mul, McDone-with-start, timeout, resets).
module tb_hazard_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE, McDone;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McError;
  logic [CNT_W-1:0] StallCount;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .McStartE(McStartE), .McDone(McDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McBusy(McBusy), .McError(McError), .StallCount(StallCount)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pcsrc;
    logic [1:0] fa, fb;
    logic       sf, se, fd, fe, fm;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                              input int rde, input int rdm, input int rdw,
                              input int rwm, input int rww, input int ld, input int pcsrc,
                              input int fa, input int fb, input int sf, input int se,
                              input int fd, input int fe, input int fm);
    vec_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde  = 5'(rde);  v.rdm  = 5'(rdm);  v.rdw  = 5'(rdw);
    v.rwm  = 1'(rwm);  v.rww  = 1'(rww);  v.ld   = 1'(ld);   v.pcsrc = 1'(pcsrc);
    v.fa   = 2'(fa);   v.fb   = 2'(fb);
    v.sf   = 1'(sf);   v.se   = 1'(se);   v.fd   = 1'(fd);   v.fe = 1'(fe); v.fm = 1'(fm);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0; McDone = 0;
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE0 = v.ld; PCSrcE = v.pcsrc;
    McStartE = 0; McDone = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  wire [9:0] obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM};
  wire [3:0] mc_obs = {StallF, StallD, StallE, FlushM};

  initial begin
    vecs[0]  = mk(0,0,5,0, 0,5,5, 1,1,0,0, 2,0, 0,0,0,0,0);
    vecs[1]  = mk(0,0,5,0, 0,5,5, 0,1,0,0, 1,0, 0,0,0,0,0);
    vecs[2]  = mk(0,0,0,0, 0,0,0, 1,1,0,0, 0,0, 0,0,0,0,0);
    vecs[3]  = mk(0,0,3,9, 0,3,9, 1,1,0,0, 2,1, 0,0,0,0,0);
    vecs[4]  = mk(0,0,4,4, 0,4,4, 0,0,0,0, 0,0, 0,0,0,0,0);
    vecs[5]  = mk(0,0,6,6, 0,6,6, 1,1,0,0, 2,2, 0,0,0,0,0);
    vecs[6]  = mk(1,7,0,0, 7,0,0, 0,0,1,0, 0,0, 1,0,0,1,0);
    vecs[7]  = mk(0,0,0,0, 0,0,0, 0,0,1,0, 0,0, 0,0,0,0,0);
    vecs[8]  = mk(7,2,0,0, 7,0,0, 0,0,1,0, 0,0, 1,0,0,1,0);
    vecs[9]  = mk(7,7,0,0, 7,0,0, 0,0,0,0, 0,0, 0,0,0,0,0);
    vecs[10] = mk(1,7,0,0, 7,0,0, 0,0,1,1, 0,0, 1,0,1,1,0);
    vecs[11] = mk(0,0,0,0, 0,0,0, 0,0,0,1, 0,0, 0,0,1,1,0);
    vecs[12] = mk(0,0,9,0, 0,8,8, 1,1,0,0, 0,0, 0,0,0,0,0);

    // Reset with hazard-provoking inputs: everything must be quiet.
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1; McStartE = 1;
    #1;
    check("reset_outputs", {22'd0, obs}, 32'd0);
    check("reset_status", {McBusy, McError, StallCount}, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), {22'd0, obs},
            {22'd0, vecs[i].fa, vecs[i].fb, vecs[i].sf, vecs[i].sf, vecs[i].se,
             vecs[i].fd, vecs[i].fe, vecs[i].fm});
    end

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3)); RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      #1;
      check($sformatf("fwd_rand%0d", i), {28'd0, ForwardAE, ForwardBE},
            {28'd0, ref_fwd(Rs1E), ref_fwd(Rs2E)});
    end

    // Multi-cycle op finishing after 4 stalled cycles; branch + load-use during BUSY.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      clear_inputs();
      McStartE = (c <= 4);
      McDone   = (c == 4);
      if (c == 2) begin
        PCSrcE = 1; ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      end
      #1;
      check($sformatf("mul_stall_c%0d", c), {28'd0, mc_obs}, (c <= 3) ? 32'hF : 32'h0);
      check($sformatf("mul_busy_c%0d", c), {31'd0, McBusy}, (c >= 1 && c <= 4) ? 1 : 0);
      if (c == 2) check("branch_in_busy", {30'd0, FlushD, FlushE}, 0);
    end
    check("mul_stallcount", {28'd0, StallCount}, 4);

    // McDone together with start: no stall, stays idle.
    @(negedge clk);
    McStartE = 1; McDone = 1;
    #1;
    check("start_done_stall", {28'd0, mc_obs}, 0);
    @(negedge clk);
    McStartE = 0; McDone = 0;
    #1;
    check("start_done_idle", {31'd0, McBusy}, 0);

    // Timeout: McDone never arrives.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      McStartE = 1; McDone = 0;
      #1;
      check($sformatf("tmo_c%0d", c), {27'd0, McError, McBusy, StallF, StallE, FlushM},
            {27'd0, 1'(c >= 9), 1'(c >= 1 && c <= 8), 3'b111});
      if (c == 13) check("tmo_stallcount13", {28'd0, StallCount}, 13);
    end
    check("stallcount_saturated", {28'd0, StallCount}, 15);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("err_reset_outputs", {22'd0, obs}, 0);
    @(negedge clk);
    reset = 1'b0;
    McStartE = 0;
    #1;
    check("err_after_reset", {McError, McBusy, StallF, StallCount}, 0);

    // Reset in the middle of BUSY.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      McStartE = 1; McDone = 0;
    end
    #1;
    check("midbusy_before", {31'd0, McBusy}, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    McStartE = 0;
    #1;
    check("midbusy_after", {McBusy, McError, StallF, StallE, FlushM, StallCount}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
